// File: rtl/cla_serial_add_ctrl.sv
// Serial adder controller: steps one 2-bit carry-lookahead slice across WIDTH-bit operands, LSB digit first.
// Optional subtract mode (adds port sub) is enabled by defining SERIAL_ADD_SUB_EN.
module cla_serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovr
);

    localparam int unsigned DIGITS = WIDTH / 2;
    localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovr_q, ovr_d;

    logic [WIDTH-1:0]   b_eff_in;
    logic               cin_eff_in;
    logic [1:0]         sl_a, sl_b, sl_g, sl_p, sl_sum;
    logic               sl_c1, sl_co;

    // Capture-time operand conditioning: subtract is a + ~b + 1
`ifdef SERIAL_ADD_SUB_EN
    assign b_eff_in   = sub ? ~b : b;
    assign cin_eff_in = sub ? 1'b1 : cin;
`else
    assign b_eff_in   = b;
    assign cin_eff_in = cin;
`endif

    // 2-bit carry-lookahead slice on the current digit
    always_comb begin
        sl_a   = op_a_q[{cnt_q, 1'b0} +: 2];
        sl_b   = op_b_q[{cnt_q, 1'b0} +: 2];
        sl_g   = sl_a & sl_b;
        sl_p   = sl_a ^ sl_b;
        sl_c1  = sl_g[0] | (sl_p[0] & carry_q);
        sl_co  = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & carry_q);
        sl_sum = sl_p ^ {sl_c1, carry_q};
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovr_d   = ovr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    op_a_d  = a;
                    op_b_d  = b_eff_in;
                    carry_d = cin_eff_in;
                    cnt_d   = '0;
                    psum_d  = '0;
                end
            end
            ST_RUN: begin
                psum_d[{cnt_q, 1'b0} +: 2] = sl_sum;
                carry_d = sl_co;
                if (cnt_q == CNT_W'(DIGITS - 1)) begin
                    state_d = ST_DONE;
                    sum_d   = psum_d;
                    cout_d  = sl_co;
                    ovr_d   = (op_a_q[MSB] == op_b_q[MSB]) && (psum_d[MSB] != op_a_q[MSB]);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            psum_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            psum_q  <= psum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovr  = ovr_q;

endmodule
